io_uart_hub: RTL and testbench
==============================

Name: io_uart_hub

Overview:
- Parametrised multi-channel UART bridge on the HPS 16-bit serial IO bus; successor to the fixed five-port 6850-style decoder.
- NUM_CH independent 8N1 UARTs, each with TX/RX FIFOs, a runtime baud divisor, loopback, sticky error flags and maskable interrupts.
- Generates its own bus acknowledge and a combined IRQ. Sits between the HPS IO bridge and the GPIO serial pins (GPS, Bluetooth, touchscreen, RS232, biometric).

Parameters:
- NUM_CH, 4: number of UART channels, 1..8.
- FIFO_DEPTH, 16: entries per TX and per RX FIFO; power of two, minimum 2.
- BASE_ADDR, 16'h0200: bus base address. Channel c occupies BASE_ADDR + 16*c .. +15.
- DEFAULT_DIV, 16'd434: reset divisor in clk cycles per bit (50 MHz / 115200).

Ports:
- clk, in, 1: system clock (sys_clk domain).
- reset, in, 1: **synchronous, active-high reset.**
- address, in, 16: bus byte address.
- bus_enable, in, 1: transaction request, held high until acknowledge is seen.
- rw, in, 1: 1 = read, 0 = write.
- byte_enable, in, 2: byte lanes, [0] = low byte, [1] = high byte.
- write_data, in, 16: write data.
- read_data, out, 16: read data, valid while acknowledge is high.
- acknowledge, out, 1: transaction complete.
- irq, out, 1: OR of all enabled channel interrupt conditions.
- rxd, in, NUM_CH: serial inputs, idle high.
- txd, out, NUM_CH: serial outputs, idle high.

Behaviour:
- Reset:
  - acknowledge=0, irq=0, read_data=0, txd=all 1s.
  - FIFOs empty, flags clear, CTRL=0, DIV=DEFAULT_DIV.
  - All RX/TX FSMs return to IDLE, including mid-frame; a partially sent frame is abandoned with txd high.
- Bus handshake:
  - Transaction starts on the first cycle bus_enable=1 while acknowledge=0.
  - The next cycle, acknowledge=1 and read_data is registered.
  - acknowledge stays 1 until bus_enable=0 and drops on the cycle after.
  - Side effects (pop, push, clear) occur exactly once per transaction.
- Address decode:
  - ch = (address - BASE_ADDR) >> 4; reg = address[3:1].
  - Out-of-window address or unused reg: still acknowledged, reads 0, writes ignored.
- Register map (per channel):
  - reg0 DATA:
    - Read pops RX; read_data = {7'b0, valid, byte}.
    - If RX is empty, no pop and read_data = 0.
    - Write with byte_enable[0] pushes write_data[7:0] to TX.
    - Write while TX is full drops the byte and sets tx_drop.
  - reg1 STATUS (read-only): bit0 rx_not_empty, bit1 tx_not_full, bit2 rx_overrun, bit3 framing_err, bit4 tx_idle (TX FIFO empty and FSM idle), bit5 tx_drop; [15:8] = RX occupancy.
  - reg2 CTRL:
    - bit0 rx_ie, bit1 tx_ie, bit3 loopback (rx taken from own txd; txd pin held high).
    - Writing bit2=1 clears bits 2, 3 and 5 of STATUS; bit2 reads 0.
  - reg3 DIV:
    - Each lane is written under its byte_enable.
    - Effective divisor = max(DIV, 2).
    - A change takes effect at the next frame start; a frame in flight keeps its divisor.
- TX FSM:
  - IDLE -> START (pop FIFO, txd=0) -> DATA x8 (LSB first) -> STOP (txd=1) -> IDLE.
  - Each state lasts DIV cycles.
  - Back-to-back frames have no gap when the FIFO is non-empty.
- RX FSM:
  - rxd passes through a 2-flop synchroniser.
  - IDLE: falling edge -> START.
  - START: wait DIV/2 (integer), sample. If high, false start -> IDLE. Otherwise go to DATA.
  - DATA: sample every DIV cycles, 8 bits, then STOP.
  - STOP: sample.
    - Low: set framing_err, discard byte, return to IDLE once rxd is high.
    - High: push byte. If RX is full, drop the byte and set rx_overrun.
- FIFO rules:
  - Simultaneous push and pop on the same FIFO is legal; occupancy is unchanged.
  - Full/empty are exact: occupancy ranges 0..FIFO_DEPTH.
- irq:
  - Registered, 1-cycle latency.
  - Per channel: (rx_ie & (rx_not_empty | rx_overrun | framing_err)) | (tx_ie & tx_idle).
  - irq is the OR over all channels.

Test Plan:
- Reset then read STATUS ch0 (addr 0x0202) -> ack one cycle after bus_enable; read_data=0x0012; irq=0; txd=4'hF.
- DIV=4 on ch1, write DATA 0x55 -> txd[1] shows 0,1,0,1,0,1,0,1,0,1 for 4 cycles each (40 cycles); tx_idle returns to 1.
- Loopback ch2, DIV=4, write 0xA3 then 0x3C -> two DATA reads return 0x01A3, 0x013C; a third read returns 0x0000.
- Drive 17 frames into rxd[0] (FIFO_DEPTH=16) without reading -> occupancy 16, rx_overrun=1; with rx_ie=1, irq=1; CTRL write 0x0005 clears the flag; irq stays 1 until the FIFO is drained.
- Stop bit forced low on rxd[3] -> framing_err=1, occupancy unchanged; a 2-cycle low glitch on rxd with DIV=8 -> false start, nothing pushed.
- Assert reset mid-TX frame and during an open bus transaction -> next cycle txd=1, acknowledge=0; the following transaction is acknowledged normally; DIV reads 434.

Source files
------------

// File: rtl/io_uart_hub.sv
// io_uart_hub: NUM_CH-channel 8N1 UART bridge on the 16-bit serial IO bus.
// Latency: bus acknowledge and read data one cycle after request; irq registered, one cycle.
// Backpressure: TX writes into a full FIFO drop the byte (tx_drop); RX into a full FIFO drops (rx_overrun).
// Ports: clk/reset (sync, active high); address/bus_enable/rw/byte_enable/write_data -> read_data/acknowledge;
//        irq = OR of enabled channel interrupts; rxd/txd = per-channel serial pins, idle high.

// Generic synchronous FIFO, first-word fall-through on pop_dat.
// Latency: push visible on pop_dat the cycle after; count exact 0..DEPTH.
// Backpressure: push while full and pop while empty are ignored.
module io_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module io_uart_hub #(
    parameter int          NUM_CH      = 4,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] BASE_ADDR   = 16'h0200,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       address,
    input  logic              bus_enable,
    input  logic              rw,
    input  logic [1:0]        byte_enable,
    input  logic [15:0]       write_data,
    output logic [15:0]       read_data,
    output logic              acknowledge,
    output logic              irq,
    input  logic [NUM_CH-1:0] rxd,
    output logic [NUM_CH-1:0] txd
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;

    // ---------------- bus decode ----------------
    logic              start_txn;
    logic [15:0]       offs;
    logic              in_win;
    logic [CHW-1:0]    sel_ch;
    logic [2:0]        reg_idx;
    logic [NUM_CH-1:0] ch_hit;
    logic [15:0]       rd_mux;
    logic              unused_addr_lsb;

    logic [NUM_CH-1:0][15:0] data_w;
    logic [NUM_CH-1:0][15:0] status_w;
    logic [NUM_CH-1:0][15:0] ctrl_w;
    logic [NUM_CH-1:0][15:0] div_w;
    logic [NUM_CH-1:0]       irq_cond;

    // A transaction is taken only on the rising side of the handshake so
    // pops/pushes/clears fire exactly once however long bus_enable is held.
    assign start_txn       = bus_enable & ~acknowledge;
    assign offs            = address - BASE_ADDR;
    assign in_win          = (address >= BASE_ADDR) && (offs[15:4] < 12'(NUM_CH));
    assign sel_ch          = offs[4 +: CHW];
    assign reg_idx         = offs[3:1];
    assign unused_addr_lsb = offs[0];

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_win && sel_ch == CHW'(c)) begin
                case (reg_idx)
                    3'd0:    rd_mux = data_w[c];
                    3'd1:    rd_mux = status_w[c];
                    3'd2:    rd_mux = ctrl_w[c];
                    3'd3:    rd_mux = div_w[c];
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acknowledge <= 1'b0;
            read_data   <= '0;
            irq         <= 1'b0;
        end else begin
            irq <= |irq_cond;
            if (start_txn) begin
                acknowledge <= 1'b1;
                read_data   <= rw ? rd_mux : 16'h0000;
            end else if (acknowledge && !bus_enable) begin
                acknowledge <= 1'b0;
            end
        end
    end

    // ---------------- channels ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic        data_wr, data_rd, ctrl_wr, div_wr, flag_clr;
        logic        rx_ie, tx_ie, lb;
        logic [15:0] div_q, eff_div;
        logic        ovr, ferr, tdrop;

        // TX side
        logic          tx_full, tx_empty, tx_pop, tx_line, tx_tick, tx_idle;
        logic [7:0]    tx_head;
        logic [CW-1:0] tx_occ_unused;
        tx_state_t     tx_st, tx_nx;
        logic [15:0]   tx_cnt, tx_div;
        logic [2:0]    tx_bit;
        logic [7:0]    tx_sh;

        // RX side
        logic          rx_full, rx_empty, rx_push, rx_in, rx_fall, rx_tick, rx_half_tick;
        logic          rx_s1, rx_s2, rx_s3;
        logic [7:0]    rx_head;
        logic [CW-1:0] rx_occ;
        rx_state_t     rx_st, rx_nx;
        logic [15:0]   rx_cnt, rx_div;
        logic [2:0]    rx_bit;
        logic [7:0]    rx_sh;

        assign ch_hit[c] = start_txn & in_win & (sel_ch == CHW'(c));
        assign data_wr   = ch_hit[c] & ~rw & (reg_idx == 3'd0) & byte_enable[0];
        assign data_rd   = ch_hit[c] &  rw & (reg_idx == 3'd0);
        assign ctrl_wr   = ch_hit[c] & ~rw & (reg_idx == 3'd2) & byte_enable[0];
        assign div_wr    = ch_hit[c] & ~rw & (reg_idx == 3'd3);
        assign flag_clr  = ctrl_wr & write_data[2];
        assign eff_div   = (div_q < 16'd2) ? 16'd2 : div_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rx_ie <= 1'b0;
                tx_ie <= 1'b0;
                lb    <= 1'b0;
                div_q <= DEFAULT_DIV;
                ovr   <= 1'b0;
                ferr  <= 1'b0;
                tdrop <= 1'b0;
            end else begin
                if (ctrl_wr) begin
                    rx_ie <= write_data[0];
                    tx_ie <= write_data[1];
                    lb    <= write_data[3];
                end
                if (div_wr && byte_enable[0]) div_q[7:0]  <= write_data[7:0];
                if (div_wr && byte_enable[1]) div_q[15:8] <= write_data[15:8];
                // A new event in the same cycle as a clear wins: it must not be lost.
                if (rx_push && rx_full)                       ovr   <= 1'b1;
                else if (flag_clr)                            ovr   <= 1'b0;
                if (rx_st == RX_STOP && rx_tick && !rx_s2)    ferr  <= 1'b1;
                else if (flag_clr)                            ferr  <= 1'b0;
                if (data_wr && tx_full)                       tdrop <= 1'b1;
                else if (flag_clr)                            tdrop <= 1'b0;
            end
        end

        io_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clk(clk), .reset(reset),
            .push(data_wr), .push_dat(write_data[7:0]),
            .pop(tx_pop), .pop_dat(tx_head),
            .full(tx_full), .empty(tx_empty), .count(tx_occ_unused)
        );

        io_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clk(clk), .reset(reset),
            .push(rx_push), .push_dat(rx_sh),
            .pop(data_rd), .pop_dat(rx_head),
            .full(rx_full), .empty(rx_empty), .count(rx_occ)
        );

        // ---- TX FSM ----
        assign tx_tick = (tx_cnt == tx_div - 16'd1);

        always_ff @(posedge clk) begin
            if (reset) tx_st <= TX_IDLE;
            else       tx_st <= tx_nx;
        end

        always_comb begin
            tx_nx = tx_st;
            case (tx_st)
                TX_IDLE:  if (!tx_empty) tx_nx = TX_START;
                TX_START: if (tx_tick) tx_nx = TX_DATA;
                TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_nx = TX_STOP;
                TX_STOP:  if (tx_tick) tx_nx = tx_empty ? TX_IDLE : TX_START;
                default:  tx_nx = TX_IDLE;
            endcase
        end

        // The pop at the end of STOP chains frames with no idle gap.
        always_comb begin
            tx_pop  = 1'b0;
            tx_line = 1'b1;
            case (tx_st)
                TX_IDLE:  tx_pop  = ~tx_empty;
                TX_START: tx_line = 1'b0;
                TX_DATA:  tx_line = tx_sh[0];
                TX_STOP:  tx_pop  = tx_tick & ~tx_empty;
                default:  tx_line = 1'b1;
            endcase
        end

        // Divisor is captured at the frame start so a DIV write mid-frame
        // cannot stretch or shrink the bits already being sent.
        always_ff @(posedge clk) begin
            if (reset) begin
                tx_cnt <= '0;
                tx_div <= 16'd2;
                tx_bit <= '0;
                tx_sh  <= '0;
            end else if (tx_pop) begin
                tx_sh  <= tx_head;
                tx_div <= eff_div;
                tx_cnt <= '0;
                tx_bit <= '0;
            end else if (tx_st != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_st == TX_DATA) begin
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx_bit <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 16'd1;
                end
            end
        end

        assign tx_idle = tx_empty & (tx_st == TX_IDLE);
        assign txd[c]  = lb ? 1'b1 : tx_line;

        // ---- RX FSM ----
        assign rx_in        = lb ? tx_line : rxd[c];
        assign rx_fall      = rx_s3 & ~rx_s2;
        assign rx_tick      = (rx_cnt == rx_div - 16'd1);
        assign rx_half_tick = (rx_cnt == (rx_div >> 1) - 16'd1);

        always_ff @(posedge clk) begin
            if (reset) begin
                rx_s1 <= 1'b1;
                rx_s2 <= 1'b1;
                rx_s3 <= 1'b1;
                rx_st <= RX_IDLE;
            end else begin
                rx_s1 <= rx_in;
                rx_s2 <= rx_s1;
                rx_s3 <= rx_s2;
                rx_st <= rx_nx;
            end
        end

        always_comb begin
            rx_nx = rx_st;
            case (rx_st)
                RX_IDLE:  if (rx_fall) rx_nx = RX_START;
                RX_START: if (rx_half_tick) rx_nx = rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nx = RX_STOP;
                RX_STOP:  if (rx_tick) rx_nx = rx_s2 ? RX_IDLE : RX_BRK;
                RX_BRK:   if (rx_s2) rx_nx = RX_IDLE;
                default:  rx_nx = RX_IDLE;
            endcase
        end

        always_comb begin
            rx_push = (rx_st == RX_STOP) & rx_tick & rx_s2;
        end

        // While idle the divisor tracks DIV; it freezes once a start edge is seen.
        always_ff @(posedge clk) begin
            if (reset) begin
                rx_cnt <= '0;
                rx_div <= 16'd2;
                rx_bit <= '0;
                rx_sh  <= '0;
            end else begin
                case (rx_st)
                    RX_IDLE: begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_div <= eff_div;
                    end
                    RX_START: rx_cnt <= rx_half_tick ? 16'd0 : rx_cnt + 16'd1;
                    RX_DATA: begin
                        if (rx_tick) begin
                            rx_cnt <= '0;
                            rx_sh  <= {rx_s2, rx_sh[7:1]};
                            rx_bit <= rx_bit + 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + 16'd1;
                        end
                    end
                    RX_STOP: rx_cnt <= rx_cnt + 16'd1;
                    default: rx_cnt <= '0;
                endcase
            end
        end

        // ---- register views ----
        assign data_w[c]   = rx_empty ? 16'h0000 : {7'b0, 1'b1, rx_head};
        assign status_w[c] = {8'(rx_occ), 2'b00, tdrop, tx_idle, ferr, ovr, ~tx_full, ~rx_empty};
        assign ctrl_w[c]   = {12'h000, lb, 1'b0, tx_ie, rx_ie};
        assign div_w[c]    = div_q;
        assign irq_cond[c] = (rx_ie & (~rx_empty | ovr | ferr)) | (tx_ie & tx_idle);
    end
endmodule

// File: tb/tb_io_uart_hub.sv
module tb_io_uart_hub;
    logic        clk;
    logic        reset;
    logic [15:0] address;
    logic        bus_enable;
    logic        rw;
    logic [1:0]  byte_enable;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        acknowledge;
    logic        irq;
    logic [3:0]  rxd;
    logic [3:0]  txd;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    io_uart_hub #(
        .NUM_CH(4), .FIFO_DEPTH(16), .BASE_ADDR(16'h0200), .DEFAULT_DIV(16'd434)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .bus_enable(bus_enable),
        .rw(rw), .byte_enable(byte_enable), .write_data(write_data),
        .read_data(read_data), .acknowledge(acknowledge), .irq(irq),
        .rxd(rxd), .txd(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic r, input logic [1:0] be,
                       input logic [15:0] wd, output logic [15:0] rd, output int lat);
        @(negedge clk);
        address = a; rw = r; byte_enable = be; write_data = wd; bus_enable = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (acknowledge !== 1'b1 && lat < 20);
        rd = read_data;
        bus_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] rd;
        int lat;
        bus(a, 1'b1, 2'b11, 16'h0000, rd, lat);
        check({tag, "_ack"}, 16'(lat), 16'd1);
        check(tag, rd, exp);
    endtask

    task automatic bus_wr(input string tag, input logic [15:0] a, input logic [1:0] be,
                          input logic [15:0] wd);
        logic [15:0] rd;
        int lat;
        bus(a, 1'b0, be, wd, rd, lat);
        check({tag, "_ack"}, 16'(lat), 16'd1);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] b, input logic stop_bit, input int div);
        @(negedge clk);
        rxd[ch] = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd[ch] = b[i];
            repeat (div) @(negedge clk);
        end
        rxd[ch] = stop_bit;
        repeat (div) @(negedge clk);
        rxd[ch] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [9:0] pat;
        int n;

        reset = 1'b1; address = '0; bus_enable = 1'b0; rw = 1'b0;
        byte_enable = 2'b00; write_data = '0; rxd = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state and first STATUS read
        check("rst_ack", 16'(acknowledge), 16'd0);
        check("rst_irq", 16'(irq), 16'd0);
        check("rst_txd", 16'(txd), 16'h000F);
        check("rst_rdata", read_data, 16'h0000);
        bus_rd("status_ch0_reset", 16'h0202, 16'h0012);
        check("irq_idle", 16'(irq), 16'd0);
        bus_rd("div_ch0_reset", 16'h0206, 16'd434);

        // Address decode corner cases
        bus_rd("below_window", 16'h01FE, 16'h0000);
        bus_rd("above_window", 16'h0240, 16'h0000);
        bus_rd("unused_reg", 16'h0208, 16'h0000);

        // TX waveform on ch1 with DIV=4
        bus_wr("div_ch1", 16'h0216, 2'b11, 16'h0004);
        bus_wr("data_ch1", 16'h0210, 2'b01, 16'h0055);
        n = 0;
        while (txd[1] !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", 16'(txd[1]), 16'd0);
        pat = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            check("tx_bit", 16'(txd[1]), 16'(pat[i / 4]));
            @(negedge clk);
        end
        check("tx_line_idle", 16'(txd[1]), 16'd1);
        bus_rd("status_ch1_idle", 16'h0212, 16'h0012);

        // Loopback on ch2
        bus_wr("ctrl_ch2_lb", 16'h0224, 2'b01, 16'h0008);
        bus_wr("div_ch2", 16'h0226, 2'b11, 16'h0004);
        bus_wr("data_ch2_a", 16'h0220, 2'b01, 16'h00A3);
        bus_wr("data_ch2_b", 16'h0220, 2'b01, 16'h003C);
        repeat (20) @(negedge clk);
        check("lb_pin_high", 16'(txd[2]), 16'd1);
        repeat (100) @(negedge clk);
        bus_rd("ctrl_ch2_read", 16'h0224, 16'h0008);
        bus_rd("lb_rx_1", 16'h0220, 16'h01A3);
        bus_rd("lb_rx_2", 16'h0220, 16'h013C);
        bus_rd("lb_rx_empty", 16'h0220, 16'h0000);

        // RX overrun on ch0, DIV=8, rx_ie=1
        bus_wr("div_ch0", 16'h0206, 2'b11, 16'h0008);
        bus_wr("ctrl_ch0_ie", 16'h0204, 2'b01, 16'h0001);
        for (int i = 0; i < 17; i++) send_frame(0, 8'(8'h10 + i), 1'b1, 8);
        repeat (4) @(negedge clk);
        bus_rd("status_ch0_ovr", 16'h0202, 16'h1017);
        check("irq_ovr", 16'(irq), 16'd1);
        bus_wr("ctrl_ch0_clr", 16'h0204, 2'b01, 16'h0005);
        bus_rd("status_ch0_clr", 16'h0202, 16'h1013);
        bus_rd("ctrl_ch0_read", 16'h0204, 16'h0001);
        check("irq_after_clr", 16'(irq), 16'd1);
        for (int i = 0; i < 16; i++) begin
            bus_rd("drain", 16'h0200, 16'h0100 | 16'(8'h10 + i));
            if (i == 14) check("irq_before_last", 16'(irq), 16'd1);
        end
        @(negedge clk);
        check("irq_drained", 16'(irq), 16'd0);
        bus_rd("status_ch0_empty", 16'h0202, 16'h0012);

        // Framing error and false start on ch3, DIV=8 written lane by lane
        bus_wr("div_ch3_hi", 16'h0236, 2'b10, 16'h0000);
        bus_wr("div_ch3_lo", 16'h0236, 2'b01, 16'hFF08);
        bus_rd("div_ch3_read", 16'h0236, 16'h0008);
        send_frame(3, 8'h5A, 1'b0, 8);
        repeat (4) @(negedge clk);
        bus_rd("status_ch3_ferr", 16'h0232, 16'h001A);
        bus_wr("ctrl_ch3_clr", 16'h0234, 2'b01, 16'h0004);
        @(negedge clk);
        rxd[3] = 1'b0;
        repeat (2) @(negedge clk);
        rxd[3] = 1'b1;
        repeat (30) @(negedge clk);
        bus_rd("status_ch3_glitch", 16'h0232, 16'h0012);
        send_frame(3, 8'h96, 1'b1, 8);
        repeat (4) @(negedge clk);
        bus_rd("rx_ch3_after_glitch", 16'h0230, 16'h0196);

        // Reset mid-frame and during an open transaction
        bus_wr("data_ch1_zero", 16'h0210, 2'b01, 16'h0000);
        repeat (10) @(negedge clk);
        check("tx_mid_frame_low", 16'(txd[1]), 16'd0);
        address = 16'h0212; rw = 1'b1; byte_enable = 2'b11; bus_enable = 1'b1;
        @(negedge clk);
        check("open_txn_ack", 16'(acknowledge), 16'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 16'(acknowledge), 16'd0);
        check("rst_mid_txd", 16'(txd), 16'h000F);
        check("rst_mid_rdata", read_data, 16'h0000);
        check("rst_mid_irq", 16'(irq), 16'd0);
        reset = 1'b0;
        bus_enable = 1'b0;
        @(negedge clk);
        bus_rd("div_ch1_after_rst", 16'h0216, 16'd434);
        bus_rd("status_ch1_after_rst", 16'h0212, 16'h0012);
        bus_rd("ctrl_ch2_after_rst", 16'h0224, 16'h0000);

        // TX FIFO overflow on ch1 at the default divisor
        for (int i = 0; i < 18; i++) bus_wr("fill_tx", 16'h0210, 2'b01, 16'(i));
        bus_rd("status_ch1_drop", 16'h0212, 16'h0020);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
